// File: rtl/fp16_pkg.sv
// Shared fp16 constants and the result-FIFO entry layout used by the adder front/back end.
package fp16_pkg;

  localparam int FP16_W       = 16;
  localparam int FP16_ADD_LAT = 6;

  localparam logic [FP16_W-1:0] FP16_QNAN_NEG = 16'hFE00;
  localparam logic [FP16_W-1:0] FP16_PINF     = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NINF     = 16'hFC00;

  // exc=1 means the adder dropped result-valid (INF/NaN outcome)
  typedef struct packed {
    logic              exc;
    logic [FP16_W-1:0] data;
  } fadd_res_t;

endpackage

// File: rtl/fadd_res_fifo.sv
// First-word-fall-through result FIFO; pointers carry one extra wrap bit to tell full from empty.
module fadd_res_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // The upstream credit counter must make this impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Joins two operand streams into a fixed-latency fp16 adder with no backpressure and
// re-streams its results; a credit counter reserves FIFO space for every issued pair.
module fadd_issue_ctrl
  import fp16_pkg::*;
#(
  parameter int LAT   = FP16_ADD_LAT,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [FP16_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [FP16_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  output logic [FP16_W-1:0] op_a_tdata,
  output logic [FP16_W-1:0] op_b_tdata,
  output logic              op_tvalid,
  input  logic [FP16_W-1:0] res_tdata,
  input  logic              res_tvalid,
  output logic [FP16_W-1:0] m_axis_result_tdata,
  output logic              m_axis_result_tuser,
  output logic              m_axis_result_tvalid,
  input  logic              m_axis_result_tready,
  output logic [CW-1:0]     stat_credit,
  output logic              stat_orphan
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              fire, pop, fifo_empty, wr_en;
  logic [CW-1:0]     credit_q, credit_d;
  logic              op_tvalid_q, op_tvalid_d;
  logic [FP16_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [LAT:1]      tok_q, tok_d;
  logic              orphan_q, orphan_d;
  fadd_res_t         wr_ent, head;

  always_comb begin
    pop  = aresetn & ~fifo_empty & m_axis_result_tready;
    // A pop frees a slot this edge, so issue may proceed at full credit.
    fire = aresetn & s_axis_a_tvalid & s_axis_b_tvalid & ((credit_q < DEPTH_C) | pop);

    op_tvalid_d = fire;
    op_a_d      = fire ? s_axis_a_tdata : op_a_q;
    op_b_d      = fire ? s_axis_b_tdata : op_b_q;

    credit_d = credit_q;
    if (fire && !pop)      credit_d = credit_q + CW'(1);
    else if (pop && !fire) credit_d = credit_q - CW'(1);

    tok_d[1] = op_tvalid_q;
    for (int i = 2; i <= LAT; i++) tok_d[i] = tok_q[i-1];

    wr_en       = tok_q[LAT];
    wr_ent.exc  = ~res_tvalid;
    wr_ent.data = res_tdata;
    orphan_d    = orphan_q | (res_tvalid & ~tok_q[LAT]);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      op_tvalid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      tok_q       <= '0;
      credit_q    <= '0;
      orphan_q    <= 1'b0;
    end else begin
      op_tvalid_q <= op_tvalid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      tok_q       <= tok_d;
      credit_q    <= credit_d;
      orphan_q    <= orphan_d;
    end
  end

  fadd_res_fifo #(
    .W     ($bits(fadd_res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (wr_en),
    .wr_data (wr_ent),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign s_axis_a_tready      = fire;
  assign s_axis_b_tready      = fire;
  assign op_a_tdata           = op_a_q;
  assign op_b_tdata           = op_b_q;
  assign op_tvalid            = op_tvalid_q;
  assign m_axis_result_tvalid = aresetn & ~fifo_empty;
  assign m_axis_result_tdata  = head.data;
  assign m_axis_result_tuser  = head.exc;
  assign stat_credit          = credit_q;
  assign stat_orphan          = orphan_q;

endmodule

// File: doc/fadd_issue_ctrl.md
Name: fadd_issue_ctrl

Overview:
- Stream front/back end for the fixed-latency fp16 adder `fpu_add_pipe`. That adder has no backpressure and its result-valid drops on INF/NaN.
- This block joins two AXI-Stream operand channels and issues operand pairs to the adder.
- It tracks in-flight operations with a token chain and captures every result into a FIFO.
- It presents results on an AXI-Stream master with tready. A credit counter guarantees the FIFO never overflows.

Parameters:
- LAT, 6: adder latency in clock edges, counted from the sampling edge to the result-register update.
- DEPTH, 8: result FIFO entries; power of two, ≥2.
- CW, 4: credit counter width, equal to clog2(DEPTH+1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_axis_a_tdata  in  16  operand A, fp16
- s_axis_a_tvalid  in  1  A valid
- s_axis_a_tready  out  1  A accepted
- s_axis_b_tdata  in  16  operand B, fp16
- s_axis_b_tvalid  in  1  B valid
- s_axis_b_tready  out  1  B accepted
- op_a_tdata  out  16  to adder s_axis_a_tdata
- op_b_tdata  out  16  to adder s_axis_b_tdata
- op_tvalid  out  1  to both adder tvalid inputs
- res_tdata  in  16  from adder m_axis_result_tdata
- res_tvalid  in  1  from adder m_axis_result_tvalid; 0 means exception
- m_axis_result_tdata  out  16  result
- m_axis_result_tuser  out  1  1 = adder flagged INF/NaN
- m_axis_result_tvalid  out  1  result valid
- m_axis_result_tready  in  1  downstream ready
- stat_credit  out  CW  FIFO occupancy plus in-flight count
- stat_orphan  out  1  sticky: res_tvalid seen with no token

Behaviour:
- Reset: aresetn sampled low at a rising aclk edge clears the following:
  - op_tvalid, op_a/b_tdata (to 0), token chain, FIFO pointers, credit, stat_orphan.
  - While aresetn is low, both s tready are 0 and m_axis_result_tvalid is 0.
  - Reset mid-operation discards in-flight results: the adder is not reset, but its outputs are ignored because no token exists.
- Pop = m_axis_result_tvalid & m_axis_result_tready.
- Join/issue rule:
  - fire = a_tvalid & b_tvalid & (credit < DEPTH | pop).
  - s_axis_a_tready = s_axis_b_tready = fire; the two channels always handshake together.
  - The pop term is a deliberate combinational path from m_axis_result_tready to s tready.
- Issue register:
  - On fire, op_a/b_tdata load A/B and op_tvalid <= 1; otherwise op_tvalid <= 0 and data holds.
  - One pair is issued per cycle maximum, with full throughput.
- Token chain:
  - LAT flops, tok[1] <= op_tvalid, tok[i] <= tok[i-1].
  - tok[LAT]=1 marks the cycle in which res_tdata belongs to an issued pair.
- Capture:
  - When tok[LAT]=1, write {~res_tvalid, res_tdata} into the FIFO. This happens regardless of res_tvalid.
  - When res_tvalid=1 and tok[LAT]=0, do not write; set stat_orphan.
- FIFO:
  - First-word-fall-through, DEPTH entries, pointers one bit wider than the address, wrap modulo DEPTH.
  - m_axis_result_tvalid = !empty; tdata and tuser come from the head entry.
  - Data must hold stable while tvalid=1 and tready=0.
  - Simultaneous write and pop: occupancy unchanged, and both take effect.
  - Write while full cannot occur because of credit; add an assertion.
- Credit:
  - +1 on fire, −1 on pop, unchanged when both occur.
  - Range 0..DEPTH; saturation never occurs.
  - Equals occupancy + (op_tvalid + popcount(tok)).
- Latency:
  - fire at edge 0, FIFO write at edge LAT+1, m_axis_result_tvalid high after edge LAT+1 when the FIFO was empty.
  - With LAT=6 that is 7 cycles from accept to output.
- Ordering: strictly in order; the adder and FIFO are both in-order.

Decomposition:
- Shared package fp16_pkg:
  - FP16_W=16 and FP16_ADD_LAT=6 (the default for LAT).
  - Constants FP16_QNAN_NEG=16'hFE00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00.
- One sub-module is natural: fadd_res_fifo, a FWFT FIFO parameterised by width (17) and DEPTH.
- Join, credit and token chain stay in the top level.

Test Plan:
- A=3C00, B=3C00, one pair, m_tready=1 (bench uses real fpu_add_pipe) → result 4000, tuser=0, tvalid pulse 7 cycles after accept; credit returns to 0.
- A=3C00, B=BC00 → result 0000, tuser=0.
- A=7C00, B=FC00 → result FE00, tuser=1; captured even though res_tvalid=0; stat_orphan stays 0.
- m_tready=0, 10 back-to-back pairs (1..10 × 3C00 variants) → exactly 8 accepted, tready then 0, credit=8.
  - Raise m_tready: results drain in order, the remaining 2 pairs accepted, and issue occurs in the same cycle as pop when credit=8.
- Only A valid for 5 cycles, B valid later → no fire until both valid; a_tready=0 throughout; single result.
- Reset asserted with 4 pairs in flight → tokens cleared, no FIFO writes afterwards, tvalid=0, credit=0.
  - Forced res_tvalid=1 with no token sets stat_orphan=1.
